// File: rtl/gf_pkg.sv
// Shared constants, FSM encoding and bus helpers for the
// GF(2^16) square-root combine stage.
package gf_pkg;
    localparam int M     = 16;
    localparam int T     = 8;
    localparam int DAT_W = 144;

    localparam logic [M:0] FIELD_POLY = 17'h1100B;
    localparam logic [3:0] CNT_INIT   = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FINAL,
        DONE
    } state_e;

    typedef logic [M-1:0] coef_t;

    // x^k sits at bit 16*(8-k) of a [0:143] bus, MSB first
    function automatic coef_t coef_of(
        input logic [0:DAT_W-1] bus,
        input int               k
    );
        return bus[M*(T-k) +: M];
    endfunction
endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^16) multiplier, reduced by FIELD_POLY.
module gf_mul
    import gf_pkg::*;
(
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);
    logic [M-1:0] prod;

    always_comb begin
        prod = '0;
        for (int i = M - 1; i >= 0; i--) begin
            prod = {prod[M-2:0], 1'b0}
                 ^ (prod[M-1] ? FIELD_POLY[M-1:0] : '0);
            if (b[i]) begin
                prod = prod ^ a;
            end
        end
    end

    assign p = prod;
endmodule

// File: rtl/sqrt_combine.sv
// Computes P0 + S*P1 mod g by Horner evaluation over P1,
// one coefficient per cycle, then folds in P0.
module sqrt_combine
    import gf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [0:DAT_W-1] first_fragment_in,
    input  logic [0:DAT_W-1] second_fragment_in,
    input  logic [0:DAT_W-1] g_in,
    input  logic [0:DAT_W-1] sqrtx_in,
    output logic             busy,
    output logic             sqrt_done,
    output logic [0:DAT_W-1] result_out
);
    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [T-1:0][M-1:0]  acc_q, acc_d;
    logic [T-1:0][M-1:0]  g_q, g_d;
    logic [T-1:0][M-1:0]  s_q, s_d;
    logic [T:0][M-1:0]    p0_q, p0_d;
    logic [T:0][M-1:0]    p1_q, p1_d;
    logic [0:DAT_W-1]     res_q, res_d;
    logic                 done_q, done_d;

    logic [M-1:0]         b_sel;
    logic [M-1:0]         lead_g [T];
    logic [M-1:0]         b_s    [T];
    logic                 unused_ok;

    // the x^8 terms of g and sqrt(x) are implied, never read
    assign unused_ok = ^{g_in[0:M-1], sqrtx_in[0:M-1]};

    assign b_sel = p1_q[cnt_q];

    for (genvar k = 0; k < T; k++) begin : g_mul
        gf_mul u_lead_g (
            .a (acc_q[T-1]),
            .b (g_q[k]),
            .p (lead_g[k])
        );
        gf_mul u_b_s (
            .a (b_sel),
            .b (s_q[k]),
            .p (b_s[k])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        g_d     = g_q;
        s_d     = s_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        res_d   = res_q;
        done_d  = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k <= T; k++) begin
                        p0_d[k] = coef_of(first_fragment_in, k);
                        p1_d[k] = coef_of(second_fragment_in, k);
                    end
                    for (int k = 0; k < T; k++) begin
                        g_d[k] = coef_of(g_in, k);
                        s_d[k] = coef_of(sqrtx_in, k);
                    end
                    acc_d   = '0;
                    cnt_d   = CNT_INIT;
                    state_d = ITER;
                end
            end
            ITER: begin
                // acc*x mod g, plus the current P1 coefficient times S
                acc_d[0] = lead_g[0] ^ b_s[0];
                for (int k = 1; k < T; k++) begin
                    acc_d[k] = acc_q[k-1] ^ lead_g[k] ^ b_s[k];
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    cnt_d   = 4'd0;
                    state_d = FINAL;
                end
            end
            FINAL: begin
                for (int k = 0; k < T; k++) begin
                    res_d[M*(T-k) +: M] = acc_q[k] ^ p0_q[k];
                end
                res_d[0 +: M] = p0_q[T];
                state_d       = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            g_q     <= '0;
            s_q     <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            g_q     <= g_d;
            s_q     <= s_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign busy       = (state_q == ITER) || (state_q == FINAL);
    assign sqrt_done  = done_q;
    assign result_out = res_q;
endmodule

// File: tb/tb_sqrt_combine.sv
// Randomized and directed checks of sqrt_combine against a
// polynomial-product-then-long-division reference model.
module tb_sqrt_combine;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [0:143] p0_in;
    logic [0:143] p1_in;
    logic [0:143] g_in;
    logic [0:143] s_in;
    logic         busy;
    logic         sqrt_done;
    logic [0:143] result_out;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    sqrt_combine dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .first_fragment_in  (p0_in),
        .second_fragment_in (p1_in),
        .g_in               (g_in),
        .sqrtx_in           (s_in),
        .busy               (busy),
        .sqrt_done          (sqrt_done),
        .result_out         (result_out)
    );

    function automatic logic [15:0] cf(logic [0:143] b, int k);
        return b[16*(8-k) +: 16];
    endfunction

    function automatic logic [0:143] put(
        logic [0:143] b, int k, logic [15:0] v
    );
        logic [0:143] r;
        r = b;
        r[16*(8-k) +: 16] = v;
        return r;
    endfunction

    function automatic logic [0:143] rnd_bus();
        logic [0:143] r;
        for (int i = 0; i < 9; i++) begin
            r[16*i +: 16] = 16'($urandom());
        end
        return r;
    endfunction

    // carry-less product, then reduce the 31-bit result
    function automatic logic [15:0] gmul(logic [15:0] a, logic [15:0] b);
        logic [30:0] pr;
        pr = '0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) pr = pr ^ ({15'b0, a} << i);
        end
        for (int i = 30; i >= 16; i--) begin
            if (pr[i]) pr = pr ^ (31'h1100B << (i - 16));
        end
        return pr[15:0];
    endfunction

    // P0 + (P1 * S) mod monic g, via full product and division
    function automatic logic [0:143] model(
        logic [0:143] p0, logic [0:143] p1,
        logic [0:143] g,  logic [0:143] s
    );
        logic [15:0]  pr [16];
        logic [15:0]  c;
        logic [0:143] r;
        for (int i = 0; i < 16; i++) pr[i] = '0;
        for (int i = 0; i <= 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                pr[i+j] = pr[i+j] ^ gmul(cf(p1, i), cf(s, j));
            end
        end
        for (int d = 15; d >= 8; d--) begin
            c     = pr[d];
            pr[d] = '0;
            for (int k = 0; k < 8; k++) begin
                pr[d-8+k] = pr[d-8+k] ^ gmul(c, cf(g, k));
            end
        end
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r = put(r, k, pr[k] ^ cf(p0, k));
        end
        r = put(r, 8, cf(p0, 8));
        return r;
    endfunction

    task automatic chk(string tag, logic [0:143] got, logic [0:143] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_i(string tag, logic [31:0] got, logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic scramble();
        p0_in = rnd_bus();
        p1_in = rnd_bus();
        g_in  = rnd_bus();
        s_in  = rnd_bus();
    endtask

    // start is raised at the current negedge; a stray start pulse
    // is injected at latency step inj (ITER/FINAL/DONE) when inj>=0
    task automatic run_op(
        logic [0:143] a0, logic [0:143] a1,
        logic [0:143] ag, logic [0:143] as,
        logic [0:143] exp, string tag, int inj
    );
        int lat;
        p0_in = a0;
        p1_in = a1;
        g_in  = ag;
        s_in  = as;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        chk_i({tag, "_busy"}, 32'(busy), 1);
        chk_i({tag, "_done_lo"}, 32'(sqrt_done), 0);
        lat = 0;
        while (sqrt_done !== 1'b1 && lat < 30) begin
            start = (lat == inj);
            if (lat == inj) scramble();
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk_i({tag, "_latency"}, 32'(lat), 11);
        chk({tag, "_result"}, result_out, exp);
    endtask

    task automatic idle_check(logic [0:143] exp, string tag);
        repeat (3) @(negedge clk);
        chk_i({tag, "_idle_busy"}, 32'(busy), 0);
        chk_i({tag, "_idle_done"}, 32'(sqrt_done), 0);
        chk({tag, "_hold"}, result_out, exp);
    endtask

    initial begin
        logic [0:143] a0, a1, ag, as, ex, zero;
        int           inj_tab [6];
        int           pulses;

        inj_tab = '{-1, 3, 9, 10, 0, 6};
        zero  = '0;
        rst   = 1'b1;
        start = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_i("rst_busy", 32'(busy), 0);
        chk_i("rst_done", 32'(sqrt_done), 0);
        chk("rst_result", result_out, zero);

        // P1 = 0: result is P0, g = x^8+x+1 with junk x^8 field
        a0 = rnd_bus();
        ag = put(put(put(zero, 0, 16'h1), 1, 16'h1), 8, 16'hDEAD);
        as = rnd_bus();
        run_op(a0, zero, ag, as, a0, "p1_zero", -1);

        // P1 = 1: result is S, x^8 of S ignored
        as = zero;
        as = put(as, 0, 16'h1234);
        as = put(as, 1, 16'h2345);
        as = put(as, 2, 16'h3456);
        as = put(as, 3, 16'h4567);
        as = put(as, 4, 16'h5678);
        as = put(as, 5, 16'h6789);
        as = put(as, 6, 16'h789A);
        as = put(as, 7, 16'h9ABC);
        ex = as;
        as = put(as, 8, 16'hFFFF);
        run_op(zero, put(zero, 0, 16'h1), rnd_bus(), as, ex,
               "p1_one", -1);

        // x * x^7 = x^8 = x + 1 mod x^8+x+1
        ag = put(put(zero, 0, 16'h1), 1, 16'h1);
        ex = put(put(zero, 0, 16'h1), 1, 16'h1);
        run_op(zero, put(zero, 1, 16'h1), ag, put(zero, 7, 16'h1),
               ex, "poly_wrap", -1);

        // 0x8000 * 0x0002 wraps through the field polynomial
        run_op(zero, put(zero, 0, 16'h2), rnd_bus(),
               put(zero, 0, 16'h8000), put(zero, 0, 16'h100B),
               "field_wrap", -1);
        idle_check(put(zero, 0, 16'h100B), "field_wrap");

        for (int n = 0; n < 6; n++) begin
            a0 = rnd_bus();
            a1 = rnd_bus();
            ag = rnd_bus();
            as = rnd_bus();
            ex = model(a0, a1, ag, as);
            run_op(a0, a1, ag, as, ex, $sformatf("rand%0d", n),
                   inj_tab[n]);
        end

        // reset at N+5 aborts without a done pulse
        scramble();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_i("abort_busy", 32'(busy), 0);
        chk("abort_result", result_out, zero);
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (sqrt_done === 1'b1) pulses++;
        end
        chk_i("abort_no_done", 32'(pulses), 0);
        chk("abort_result_late", result_out, zero);

        // start together with reset is dropped
        scramble();
        start = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        chk_i("rst_start_busy", 32'(busy), 0);
        pulses = 0;
        repeat (14) begin
            @(negedge clk);
            if (sqrt_done === 1'b1) pulses++;
        end
        chk_i("rst_start_no_done", 32'(pulses), 0);

        // stray start mid-ITER, then a back-to-back request
        a0 = rnd_bus();
        a1 = rnd_bus();
        ag = rnd_bus();
        as = rnd_bus();
        ex = model(a0, a1, ag, as);
        run_op(a0, a1, ag, as, ex, "mid_iter", 4);
        a0 = rnd_bus();
        a1 = rnd_bus();
        ag = rnd_bus();
        as = rnd_bus();
        ex = model(a0, a1, ag, as);
        run_op(a0, a1, ag, as, ex, "b2b", -1);
        idle_check(ex, "b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
